// File: rtl/addition_aligner.sv
// addition_aligner
//
// Multi-cycle front end of the single-precision floating-point adder.
// Two binary32 operands are taken over a valid/ready handshake and ordered
// by magnitude. The smaller mantissa is shifted right one bit per cycle
// until it lines up with the larger exponent. The two mantissas are then
// added or subtracted. The raw result goes to the normalisation stage that
// follows this block.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands a/b are valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       binary32 operands {sign, exp[7:0], frac[22:0]}
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_s      result sign
//   out_e      result exponent, biased
//   out_m      raw mantissa: [24] carry, [23] hidden bit, [22:0] fraction
module addition_aligner (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_s,
  output logic [7:0]  out_e,
  output logic [24:0] out_m
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  // Working registers for the operation in flight.
  // L is the larger-magnitude operand and S is the smaller one.
  logic        sign_l, sign_l_nx;
  logic [7:0]  exp_l, exp_l_nx;
  logic [24:0] m_l, m_l_nx;
  logic [24:0] m_s, m_s_nx;
  logic        sub, sub_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        special, special_nx;
  logic        spec_nan, spec_nan_nx;
  logic        spec_s, spec_s_nx;

  logic        out_valid_nx;
  logic        out_s_nx;
  logic [7:0]  out_e_nx;
  logic [24:0] out_m_nx;

  // Operand field decoding. A zero exponent means zero, so denormals are
  // flushed. Otherwise the mantissa gets its hidden one, and the spare top
  // bit leaves room for the carry of the later addition.
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic [24:0] man_a, man_b;

  assign sign_a = a[31];
  assign exp_a  = a[30:23];
  assign frac_a = a[22:0];
  assign sign_b = b[31];
  assign exp_b  = b[30:23];
  assign frac_b = b[22:0];

  assign man_a = (exp_a == 8'd0) ? 25'd0 : {2'b01, frac_a};
  assign man_b = (exp_b == 8'd0) ? 25'd0 : {2'b01, frac_b};

  // Magnitude ordering. The exponent decides first and the mantissa breaks
  // ties. On a complete tie, a is the larger operand.
  logic a_is_l;
  assign a_is_l = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));

  // The alignment shift count saturates at 25. At that point the hidden bit
  // of S has certainly fallen off the end.
  logic [7:0] exp_big, exp_small, exp_diff;
  logic [4:0] cnt_init;

  assign exp_big   = a_is_l ? exp_a : exp_b;
  assign exp_small = a_is_l ? exp_b : exp_a;
  assign exp_diff  = exp_big - exp_small;
  assign cnt_init  = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];

  // Special operand classification. Any NaN gives the canonical NaN. So do
  // two infinities of opposite sign. Otherwise any infinity passes through
  // with its own sign.
  logic nan_a, nan_b, inf_a, inf_b;
  logic is_nan, is_special, inf_sign;

  assign nan_a      = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign nan_b      = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign inf_a      = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign inf_b      = (exp_b == 8'hFF) && (frac_b == 23'd0);
  assign is_nan     = nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b));
  assign is_special = (exp_a == 8'hFF) || (exp_b == 8'hFF);
  assign inf_sign   = inf_a ? sign_a : sign_b;

  // Mantissa combine. Subtraction cannot underflow because m_l >= m_s
  // always holds. A carry out of an addition lands in bit 24.
  logic [24:0] raw_sum;
  assign raw_sum = sub ? (m_l - m_s) : (m_l + m_s);

  // in_ready is decoded from the state only. It is also masked while reset
  // is held, so nothing appears acceptable during reset.
  assign in_ready = (state == IDLE) && !rst;

  // Next-state and next-register logic. Every register holds its value by
  // default. The case statement then overrides only what the current state
  // changes.
  always_comb begin
    state_nx     = state;
    sign_l_nx    = sign_l;
    exp_l_nx     = exp_l;
    m_l_nx       = m_l;
    m_s_nx       = m_s;
    sub_nx       = sub;
    cnt_nx       = cnt;
    special_nx   = special;
    spec_nan_nx  = spec_nan;
    spec_s_nx    = spec_s;
    out_valid_nx = out_valid;
    out_s_nx     = out_s;
    out_e_nx     = out_e;
    out_m_nx     = out_m;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_l_nx   = a_is_l ? sign_a : sign_b;
          exp_l_nx    = exp_big;
          m_l_nx      = a_is_l ? man_a : man_b;
          m_s_nx      = a_is_l ? man_b : man_a;
          sub_nx      = sign_a ^ sign_b;
          special_nx  = is_special;
          spec_nan_nx = is_nan;
          spec_s_nx   = inf_sign;
          cnt_nx      = is_special ? 5'd0 : cnt_init;
          state_nx    = ALIGN;
        end
      end

      ALIGN: begin
        if (cnt != 5'd0) begin
          // Bits shifted out are discarded. There are no guard or sticky bits.
          m_s_nx = m_s >> 1;
          cnt_nx = cnt - 5'd1;
        end else begin
          state_nx     = DONE;
          out_valid_nx = 1'b1;
          if (special) begin
            out_s_nx = spec_nan ? 1'b0 : spec_s;
            out_e_nx = 8'hFF;
            out_m_nx = spec_nan ? 25'h0C00000 : 25'h0800000;
          end else if (raw_sum == 25'd0) begin
            // Exact cancellation or two zeros gives a clean +0.
            out_s_nx = 1'b0;
            out_e_nx = 8'd0;
            out_m_nx = 25'd0;
          end else begin
            out_s_nx = sign_l;
            out_e_nx = exp_l;
            out_m_nx = raw_sum;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight
  // and clears the presented result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign_l    <= 1'b0;
      exp_l     <= 8'd0;
      m_l       <= 25'd0;
      m_s       <= 25'd0;
      sub       <= 1'b0;
      cnt       <= 5'd0;
      special   <= 1'b0;
      spec_nan  <= 1'b0;
      spec_s    <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= 8'd0;
      out_m     <= 25'd0;
    end else begin
      state     <= state_nx;
      sign_l    <= sign_l_nx;
      exp_l     <= exp_l_nx;
      m_l       <= m_l_nx;
      m_s       <= m_s_nx;
      sub       <= sub_nx;
      cnt       <= cnt_nx;
      special   <= special_nx;
      spec_nan  <= spec_nan_nx;
      spec_s    <= spec_s_nx;
      out_valid <= out_valid_nx;
      out_s     <= out_s_nx;
      out_e     <= out_e_nx;
      out_m     <= out_m_nx;
    end
  end

endmodule
